uart_rx_cmd_ctrl: RTL and testbench

Frame controller that sits behind the UART receiver and turns its byte stream into register write commands. It detects each completed byte from the receiver's `rx_ready` flag and parses 4-byte frames: sync, address, data, checksum. A validated frame produces a one-cycle register write strobe. Malformed, errored or stalled frames are discarded and counted.

---
 rtl/uart_rx_cmd_ctrl.sv | 133 +++++++++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: parses sync/addr/data/checksum frames from a UART byte
// stream into one-cycle register write strobes; aborted frames are counted.
`default_nettype none

module uart_rx_cmd_ctrl #(
  parameter int         fclk          = 50_000_000,
  parameter int         baud          = 115_200,
  parameter int         TIMEOUT_CHARS = 4,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
  input  logic       clk50m,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       rx_error,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       frame_err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int              TO_LIM  = TIMEOUT_CHARS * 10 * (fclk / baud) - 1;
  localparam int              TO_W    = $clog2(TO_LIM + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_LIM);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  typedef enum logic [2:0] {SYNC, ADDR, DATA, CHK, WRITE} state_t;

  state_t          state;
  state_t          state_nx;
  logic            rdy_q;
  logic            byte_evt;
  logic            clean_evt;
  logic            to_expired;
  logic            abort;
  logic            accept;
  logic [7:0]      addr_sh;
  logic [7:0]      data_sh;
  logic [TO_W-1:0] to_cnt;

  // A byte is complete on the rising edge of the receiver's ready level.
  assign byte_evt   = rx_ready & ~rdy_q;
  assign clean_evt  = byte_evt & ~rx_error;
  assign to_expired = (to_cnt == '0);
  assign busy       = (state != SYNC);

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    accept   = 1'b0;
    case (state)
      SYNC: begin
        if (clean_evt && (rx_data == SYNC_BYTE)) begin
          state_nx = ADDR;
        end
      end
      ADDR, DATA, CHK: begin
        // A byte arriving in the expiry cycle takes priority over the timeout.
        if (byte_evt) begin
          if (rx_error) begin
            abort = 1'b1;
          end else if (state == ADDR) begin
            state_nx = DATA;
          end else if (state == DATA) begin
            state_nx = CHK;
          end else if (rx_data == (SYNC_BYTE ^ addr_sh ^ data_sh)) begin
            state_nx = WRITE;
            accept   = 1'b1;
          end else begin
            abort = 1'b1;
          end
        end else if (to_expired) begin
          abort = 1'b1;
        end
        if (abort) begin
          state_nx = SYNC;
        end
      end
      WRITE:   state_nx = SYNC;
      default: state_nx = SYNC;
    endcase
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      addr_sh   <= 8'h00;
      data_sh   <= 8'h00;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= 8'h00;
      to_cnt    <= TO_LOAD;
    end else begin
      rdy_q     <= rx_ready;
      reg_we    <= accept;
      frame_err <= abort;
      if (abort && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (clean_evt && (state == ADDR)) begin
        addr_sh <= rx_data;
      end
      if (clean_evt && (state == DATA)) begin
        data_sh <= rx_data;
      end
      // Outputs are published on the edge into WRITE so they are valid with reg_we.
      if (accept) begin
        reg_addr  <= addr_sh;
        reg_wdata <= data_sh;
      end
      if (byte_evt || (state == SYNC)) begin
        to_cnt <= TO_LOAD;
      end else if ((state != WRITE) && !to_expired) begin
        to_cnt <= to_cnt - TO_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Self-checking bench for uart_rx_cmd_ctrl: vector table, cycle-exact corner
// sequences and randomized frames against a frame-level queue model.
`default_nettype none

module tb_uart_rx_cmd_ctrl;

  localparam int         FCLK   = 1_000_000;
  localparam int         BAUD   = 100_000;
  localparam int         TCHARS = 4;
  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         TO_LIM = TCHARS * 10 * (FCLK / BAUD) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] reg_addr, reg_wdata, err_cnt;
  logic       reg_we, frame_err, busy;

  uart_rx_cmd_ctrl #(
    .fclk(FCLK), .baud(BAUD), .TIMEOUT_CHARS(TCHARS), .SYNC_BYTE(SYNC)
  ) dut (
    .clk50m(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_error(rx_error), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int we_cnt = 0, fe_cnt = 0, we_cyc = -1, fe_cyc = -1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we)    begin we_cnt++; we_cyc = cyc; end
      if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    end
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Frame-level model: a frame is the queue of bytes collected since a sync byte.
  logic [7:0] q[$];
  int         m_we = 0, m_err = 0, m_err_rst = 0, m_last = 0;
  logic [7:0] m_addr = 8'h00, m_data = 8'h00;

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic model_byte(input logic [7:0] b, input logic e, input int ev);
    if (q.size() > 0 && (ev - m_last) > TO_LIM + 1) begin
      m_err++; m_err_rst++; q.delete();
    end
    m_last = ev;
    if (q.size() == 0) begin
      if (!e && b == SYNC) q.push_back(b);
    end else if (e) begin
      m_err++; m_err_rst++; q.delete();
    end else begin
      q.push_back(b);
      if (q.size() == 4) begin
        if (b == (q[0] ^ q[1] ^ q[2])) begin
          m_we++; m_addr = q[1]; m_data = q[2];
        end else begin
          m_err++; m_err_rst++;
        end
        q.delete();
      end
    end
  endtask

  task automatic model_reset();
    q.delete(); m_err_rst = 0; m_addr = 8'h00; m_data = 8'h00;
  endtask

  int last_evt = 0;

  // gap: cycles from the previous byte event to this one (minimum 2).
  task automatic send_byte(input logic [7:0] b, input logic e, input int gap);
    while (cyc < last_evt + gap) @(negedge clk);
    rx_data = b; rx_error = e; rx_ready = 1'b1;
    last_evt = cyc;
    model_byte(b, e, cyc);
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"},  reg_addr,  0);
    check({tag, "_wdata"}, reg_wdata, 0);
    check({tag, "_we"},    reg_we,    0);
    check({tag, "_ferr"},  frame_err, 0);
    check({tag, "_errcnt"}, err_cnt,  0);
    check({tag, "_busy"},  busy,      0);
  endtask

  typedef struct {
    int              n;
    logic [5:0][7:0] b;
    logic [5:0]      e;
    int              we;
    int              fe;
    logic [7:0]      addr;
    logic [7:0]      data;
  } vec_t;

  vec_t tv [10];

  initial begin
    int e_acc, we0, fe0, e1;
    logic [7:0] fb [4];
    logic       fer [4];
    int         gp [4];
    int         r;

    tv[0] = '{4, 48'hA5_12_34_83_00_00, 6'b000000, 1, 0, 8'h12, 8'h34};
    tv[1] = '{6, 48'h00_FF_A5_01_02_A6, 6'b000000, 1, 0, 8'h01, 8'h02};
    tv[2] = '{4, 48'hA5_12_34_00_00_00, 6'b000000, 0, 1, 8'h01, 8'h02};
    tv[3] = '{3, 48'hA5_12_34_00_00_00, 6'b001000, 0, 1, 8'h01, 8'h02};
    tv[4] = '{4, 48'hA5_A5_A5_A5_00_00, 6'b000000, 1, 0, 8'hA5, 8'hA5};
    tv[5] = '{5, 48'hA5_A5_00_00_A5_00, 6'b100000, 1, 0, 8'h00, 8'h00};
    tv[6] = '{4, 48'hA5_10_20_94_00_00, 6'b000000, 0, 1, 8'h00, 8'h00};
    tv[7] = '{4, 48'hA5_A5_01_A6_00_00, 6'b010000, 0, 1, 8'h00, 8'h00};
    tv[8] = '{4, 48'hA5_10_20_95_00_00, 6'b000000, 1, 0, 8'h10, 8'h20};
    tv[9] = '{4, 48'hA5_01_02_A6_00_00, 6'b000100, 0, 1, 8'h10, 8'h20};

    idle(3);
    check_zero("reset");
    rst_n = 1'b1;
    idle(3);

    e_acc = 0;
    for (int i = 0; i < 10; i++) begin
      we0 = we_cnt; fe0 = fe_cnt;
      for (int k = 0; k < tv[i].n; k++) send_byte(tv[i].b[5-k], tv[i].e[5-k], 20);
      idle(10);
      e_acc = sat(e_acc + tv[i].fe);
      check($sformatf("vec%0d_we", i),     we_cnt - we0, tv[i].we);
      check($sformatf("vec%0d_ferr", i),   fe_cnt - fe0, tv[i].fe);
      check($sformatf("vec%0d_errcnt", i), err_cnt, e_acc);
      check($sformatf("vec%0d_addr", i),   reg_addr, tv[i].addr);
      check($sformatf("vec%0d_wdata", i),  reg_wdata, tv[i].data);
      check($sformatf("vec%0d_busy", i),   busy, 0);
    end

    // Cycle-exact valid frame: strobe and busy relative to the checksum byte.
    send_byte(8'hA5, 1'b0, 20);
    check("exact_busy_after_sync", busy, 1);
    send_byte(8'h5A, 1'b0, 20);
    send_byte(8'h3C, 1'b0, 20);
    send_byte(8'hA5 ^ 8'h5A ^ 8'h3C, 1'b0, 20);
    check("exact_we_n1", reg_we, 1);
    check("exact_busy_write", busy, 1);
    check("exact_addr_n1", reg_addr, 8'h5A);
    check("exact_wdata_n1", reg_wdata, 8'h3C);
    idle(1);
    check("exact_we_n2", reg_we, 0);
    check("exact_busy_n2", busy, 0);

    // Cycle-exact abort pulse on a checksum mismatch.
    send_byte(8'hA5, 1'b0, 20);
    send_byte(8'h01, 1'b0, 20);
    send_byte(8'h02, 1'b0, 20);
    send_byte(8'h00, 1'b0, 20);
    check("chkerr_ferr_n1", frame_err, 1);
    check("chkerr_busy_n1", busy, 0);
    idle(1);
    check("chkerr_ferr_n2", frame_err, 0);

    // Timeout after the address byte, then recovery.
    fe0 = fe_cnt;
    send_byte(8'hA5, 1'b0, 20);
    send_byte(8'h12, 1'b0, 20);
    e1 = last_evt;
    while (fe_cnt == fe0 && cyc < e1 + TO_LIM + 50) @(negedge clk);
    check("timeout_ferr", fe_cnt - fe0, 1);
    check("timeout_cycle", fe_cyc, e1 + TO_LIM + 2);
    check("timeout_busy", busy, 0);
    we0 = we_cnt;
    send_byte(8'hA5, 1'b0, 20);
    send_byte(8'h33, 1'b0, 20);
    send_byte(8'h44, 1'b0, 20);
    send_byte(8'hA5 ^ 8'h33 ^ 8'h44, 1'b0, 20);
    idle(5);
    check("timeout_recover_we", we_cnt - we0, 1);
    check("timeout_recover_addr", reg_addr, 8'h33);

    // A byte landing exactly on the expiry cycle wins; one cycle later it does not.
    we0 = we_cnt; fe0 = fe_cnt;
    send_byte(8'hA5, 1'b0, 20);
    send_byte(8'h12, 1'b0, 20);
    send_byte(8'h34, 1'b0, TO_LIM + 1);
    send_byte(8'h83, 1'b0, 20);
    idle(5);
    check("edge_we", we_cnt - we0, 1);
    check("edge_ferr", fe_cnt - fe0, 0);
    we0 = we_cnt;
    send_byte(8'hA5, 1'b0, 20);
    send_byte(8'h12, 1'b0, 20);
    send_byte(8'h34, 1'b0, TO_LIM + 2);
    send_byte(8'h83, 1'b0, 20);
    idle(5);
    check("late_we", we_cnt - we0, 0);
    check("late_ferr", fe_cnt - fe0, 1);

    // Randomized frames against the model.
    for (int i = 0; i < 120; i++) begin
      fb[0] = SYNC; fb[1] = 8'($urandom); fb[2] = 8'($urandom);
      fb[3] = fb[0] ^ fb[1] ^ fb[2];
      for (int k = 0; k < 4; k++) begin fer[k] = 1'b0; gp[k] = $urandom_range(2, 30); end
      r = $urandom_range(0, 99);
      if (r < 15)      fb[3] = fb[3] ^ 8'($urandom_range(1, 255));
      else if (r < 25) fer[$urandom_range(0, 3)] = 1'b1;
      else if (r < 33) gp[$urandom_range(1, 3)] = TO_LIM + 1 + $urandom_range(0, 2);
      else if (r < 38) fb[0] = 8'($urandom);
      if ($urandom_range(0, 9) == 0) send_byte(8'($urandom), 1'($urandom), $urandom_range(2, 30));
      for (int k = 0; k < 4; k++) send_byte(fb[k], fer[k], gp[k]);
      idle(10);
      check($sformatf("rnd%0d_we", i),     we_cnt, m_we);
      check($sformatf("rnd%0d_ferr", i),   fe_cnt, m_err);
      check($sformatf("rnd%0d_errcnt", i), err_cnt, sat(m_err_rst));
      check($sformatf("rnd%0d_addr", i),   reg_addr, m_addr);
      check($sformatf("rnd%0d_wdata", i),  reg_wdata, m_data);
    end

    // Saturation of the abort counter.
    fe0 = fe_cnt;
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5, 1'b0, 20);
      send_byte(8'h12, 1'b0, 4);
      send_byte(8'h34, 1'b0, 4);
      send_byte(8'h00, 1'b0, 4);
    end
    idle(5);
    check("sat_errcnt", err_cnt, 8'hFF);
    check("sat_pulses", fe_cnt - fe0, 300);
    check("sat_model", err_cnt, sat(m_err_rst));
    send_byte(8'hA5, 1'b0, 20);
    send_byte(8'h12, 1'b0, 4);
    send_byte(8'h34, 1'b0, 4);
    send_byte(8'h00, 1'b0, 4);
    idle(5);
    check("sat_hold", err_cnt, 8'hFF);

    // Reset in the middle of a frame.
    we0 = we_cnt;
    send_byte(8'hA5, 1'b0, 20);
    send_byte(8'h12, 1'b0, 20);
    rst_n = 1'b0;
    model_reset();
    idle(2);
    check_zero("midrst");
    rst_n = 1'b1;
    idle(2);
    send_byte(8'h34, 1'b0, 20);
    send_byte(8'h83, 1'b0, 20);
    idle(10);
    check("midrst_no_we", we_cnt - we0, 0);
    check_zero("midrst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
